// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler driving one UART TX line; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_sched #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 done,
   output logic [PTR_W-1:0]     done_id,
   output logic                 busy,
   output logic                 baud_en,
   input  logic                 baud_tick,
   output logic                 txd
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t             state, state_n;
   logic [PTR_W-1:0]   last, last_n;
   logic [7:0]         shreg, shreg_n;
   logic [2:0]         cnt, cnt_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic               done_n, busy_n, baud_en_n, txd_n;
   logic [PTR_W-1:0]   done_id_n;
`ifdef UART_TX_PARITY_EN
   logic               par, par_n;
`endif

   logic               any_req, hi_found;
   logic [PTR_W-1:0]   hi_sel, lo_sel, sel;
   logic [7:0]         sel_byte;

   // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      any_req  = 1'b0;
      hi_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any_req = 1'b1;
            lo_sel  = PTR_W'(i);
            if (i > int'(last)) begin
               hi_found = 1'b1;
               hi_sel   = PTR_W'(i);
            end
         end
      end
      sel      = hi_found ? hi_sel : lo_sel;
      sel_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PTR_W'(i) == sel) begin
            sel_byte = data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_n   = state;
      last_n    = last;
      shreg_n   = shreg;
      cnt_n     = cnt;
      gnt_n     = '0;
      done_n    = 1'b0;
      done_id_n = done_id;
      busy_n    = busy;
      baud_en_n = baud_en;
      txd_n     = txd;
`ifdef UART_TX_PARITY_EN
      par_n     = par;
`endif
      case (state)
         IDLE: begin
            txd_n = 1'b1;
            if (any_req) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  gnt_n[i] = (PTR_W'(i) == sel);
               end
               shreg_n   = sel_byte;
               last_n    = sel;
               busy_n    = 1'b1;
               baud_en_n = 1'b1;
               txd_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_n     = ^sel_byte;
`endif
               state_n   = START;
            end
         end
         START: begin
            if (baud_tick) begin
               txd_n   = shreg[0];
               cnt_n   = 3'd0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  txd_n   = par;
                  state_n = PARITY;
`else
                  txd_n   = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  shreg_n = {1'b0, shreg[7:1]};
                  cnt_n   = cnt + 3'd1;
                  txd_n   = shreg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               txd_n   = 1'b1;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            txd_n = 1'b1;
            if (baud_tick) begin
               done_n    = 1'b1;
               done_id_n = last;
               baud_en_n = 1'b0;
               busy_n    = 1'b0;
               state_n   = IDLE;
            end
         end
         default: begin
            txd_n     = 1'b1;
            baud_en_n = 1'b0;
            busy_n    = 1'b0;
            state_n   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last    <= PTR_W'(NUM_REQ - 1);
         shreg   <= '0;
         cnt     <= '0;
         gnt     <= '0;
         done    <= 1'b0;
         done_id <= '0;
         busy    <= 1'b0;
         baud_en <= 1'b0;
         txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         last    <= last_n;
         shreg   <= shreg_n;
         cnt     <= cnt_n;
         gnt     <= gnt_n;
         done    <= done_n;
         done_id <= done_id_n;
         busy    <= busy_n;
         baud_en <= baud_en_n;
         txd     <= txd_n;
`ifdef UART_TX_PARITY_EN
         par     <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized bench for uart_tx_sched against a queue-based frame model
module tb_uart_tx_sched;
   localparam int NUM_REQ  = 4;
   localparam int PTR_W    = 2;
   localparam int TICK_DIV = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]   gnt;
   logic                 done;
   logic [PTR_W-1:0]     done_id;
   logic                 busy;
   logic                 baud_en;
   logic                 baud_tick;
   logic                 txd;

   uart_tx_sched #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .done(done),
      .done_id(done_id), .busy(busy), .baud_en(baud_en), .baud_tick(baud_tick), .txd(txd)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] q [NUM_REQ][$];
   int         m_last, cur_id, nrx, gnt_cyc, cyc, tcnt;
   int         n_grants, n_aborted, n_frames;
   logic [7:0] cur_byte;
   logic [15:0] rx;
   bit         in_frame, exp_b2b, force_tick;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick();
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (m_last + k) % NUM_REQ;
         if (q[idx].size() > 0) return idx;
      end
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NUM_REQ; i++) if (q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {5'b0, 1'b1, ^b, b, 1'b0};
`else
      return {6'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   task automatic refresh();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i]         = (q[i].size() > 0);
         data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      end
   endtask

   task automatic push(input int i, input logic [7:0] b);
      q[i].push_back(b);
      refresh();
   endtask

   task automatic monitor();
      int e;
      if (rst) begin
         check("rst_txd", txd, 1);
         check("rst_gnt", gnt, 0);
         check("rst_done", done, 0);
         check("rst_done_id", done_id, 0);
         check("rst_busy", busy, 0);
         check("rst_baud_en", baud_en, 0);
         if (in_frame) n_aborted++;
         m_last   = NUM_REQ - 1;
         in_frame = 1'b0;
         exp_b2b  = 1'b0;
         return;
      end
      if (exp_b2b) begin
         check("b2b_gnt", gnt != 0, 1);
         exp_b2b = 1'b0;
      end
      if (gnt != 0) begin
         e = model_pick();
         check("gnt", gnt, (e < 0) ? 32'd0 : (32'd1 << e));
         check("gnt_during_frame", in_frame, 0);
         check("gnt_baud_en", baud_en, 1);
         check("start_txd", txd, 0);
         if (e >= 0) begin
            cur_id   = e;
            cur_byte = q[e].pop_front();
            m_last   = e;
         end
         n_grants++;
         in_frame = 1'b1;
         nrx      = 0;
         rx       = '0;
         gnt_cyc  = cyc;
         refresh();
      end
      if (done) begin
         check("done_in_frame", in_frame, 1);
         check("done_id", done_id, cur_id);
         check("frame_len", nrx, FRAME_BITS);
         check("frame_bits", rx, exp_frame(cur_byte));
         check("frame_cycles", cyc - gnt_cyc, TICK_DIV * FRAME_BITS);
         check("done_baud_en", baud_en, 0);
`ifdef UART_TX_PARITY_EN
         check("parity_bit", rx[9], ^cur_byte);
`endif
         n_frames++;
         in_frame = 1'b0;
         exp_b2b  = (model_pick() >= 0);
      end
      check("busy", busy, in_frame);
      if (!busy) check("idle_txd", txd, 1);
   endtask

   task automatic stim_tick();
      logic t;
      t = 1'b0;
      if (!baud_en) tcnt = 0;
      else begin
         tcnt++;
         if (tcnt == TICK_DIV) begin
            t    = 1'b1;
            tcnt = 0;
         end
      end
      if (force_tick) t = 1'b1;
      if (t && in_frame && nrx < 16) begin
         rx[nrx] = txd;
         nrx++;
      end
      baud_tick = t;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      monitor();
      stim_tick();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (in_frame || busy || !all_empty()) begin
         if (n >= budget) begin
            check("drain_timeout", 0, 1);
            break;
         end
         step();
         n++;
      end
   endtask

   initial begin
      int n, i;
      rst = 1'b1; req = '0; data = '0; baud_tick = 1'b0; force_tick = 1'b0;
      tcnt = 0; cyc = 0; m_last = NUM_REQ - 1; in_frame = 1'b0; exp_b2b = 1'b0;
      n_grants = 0; n_aborted = 0; n_frames = 0; nrx = 0; rx = '0;
      cur_id = 0; cur_byte = '0; gnt_cyc = 0;

      // all four requesting through reset, requester 0 twice: 0,1,2,3,0 back to back
      push(0, 8'($urandom));
      push(1, 8'($urandom));
      push(2, 8'($urandom));
      push(3, 8'($urandom));
      push(0, 8'($urandom));
      repeat (3) step();
      rst = 1'b0;
      wait_idle(5000);

      push(2, 8'hA5);
      wait_idle(1000);

      // spurious tick while idle
      step();
      force_tick = 1'b1;
      step();
      force_tick = 1'b0;
      step();
      step();
      check("idle_tick_txd", txd, 1);
      check("idle_tick_baud_en", baud_en, 0);
      check("idle_tick_busy", busy, 0);

      // reset in the middle of data bit 3
      push(3, 8'($urandom));
      n = 0;
      while (!(in_frame && nrx >= 4) && n < 2000) begin
         step();
         n++;
      end
      check("reach_data3", in_frame && nrx >= 4, 1);
      repeat (5) step();
      push(2, 8'($urandom));
      push(0, 8'($urandom));
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_idle(2000);

      push(1, 8'h07);
      wait_idle(1000);
      push(1, 8'h03);
      wait_idle(1000);

      for (int c = 0; c < 8000; c++) begin
         step();
         if ($urandom_range(0, 29) == 0) begin
            i = $urandom_range(0, NUM_REQ - 1);
            if (q[i].size() < 3) push(i, 8'($urandom));
         end
         if (in_frame && $urandom_range(0, 149) == 0) begin
            i = $urandom_range(0, NUM_REQ - 1);
            if (q[i].size() > 0) begin
               void'(q[i].pop_back());
               refresh();
            end
         end
      end
      wait_idle(20000);
      check("frame_count", n_frames, n_grants - n_aborted);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
